// File: rtl/buzzer_pkg.sv
// Shared note/octave codes, centihertz table and half-period helper for the
// buzzer tone generator.
package buzzer_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_TI   = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam logic [1:0] OCT_LOW  = 2'b00;
  localparam logic [1:0] OCT_MID  = 2'b01;
  localparam logic [1:0] OCT_HIGH = 2'b10;

  // Middle-octave note frequencies in centihertz, do..ti
  localparam int unsigned F_CHZ_DO = 52325;
  localparam int unsigned F_CHZ_RE = 58733;
  localparam int unsigned F_CHZ_MI = 65926;
  localparam int unsigned F_CHZ_FA = 69846;
  localparam int unsigned F_CHZ_SO = 78399;
  localparam int unsigned F_CHZ_LA = 88000;
  localparam int unsigned F_CHZ_TI = 98777;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  // Clocks per half period; 64-bit because clk_freq*100 exceeds 32 bits
  function automatic logic [31:0] half_period(input longint unsigned clk_freq,
                                              input longint unsigned f_chz);
    return 32'((clk_freq * 64'd100) / (64'd2 * f_chz));
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_lut.sv
// Combinational (note, octave) -> half-period lookup with a note-valid flag.
module note_period_lut
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] hp_c,
  output logic             valid_c
);

  localparam logic [CNT_W-1:0] HP_DO = CNT_W'(half_period(CLK_FREQ, F_CHZ_DO));
  localparam logic [CNT_W-1:0] HP_RE = CNT_W'(half_period(CLK_FREQ, F_CHZ_RE));
  localparam logic [CNT_W-1:0] HP_MI = CNT_W'(half_period(CLK_FREQ, F_CHZ_MI));
  localparam logic [CNT_W-1:0] HP_FA = CNT_W'(half_period(CLK_FREQ, F_CHZ_FA));
  localparam logic [CNT_W-1:0] HP_SO = CNT_W'(half_period(CLK_FREQ, F_CHZ_SO));
  localparam logic [CNT_W-1:0] HP_LA = CNT_W'(half_period(CLK_FREQ, F_CHZ_LA));
  localparam logic [CNT_W-1:0] HP_TI = CNT_W'(half_period(CLK_FREQ, F_CHZ_TI));

  logic [CNT_W-1:0] base;

  always_comb begin
    base    = '0;
    valid_c = 1'b1;
    case (note)
      4'd1:    base = HP_DO;
      4'd2:    base = HP_RE;
      4'd3:    base = HP_MI;
      4'd4:    base = HP_FA;
      4'd5:    base = HP_SO;
      4'd6:    base = HP_LA;
      4'd7:    base = HP_TI;
      default: valid_c = 1'b0;
    endcase
  end

  // Octave code 11 falls through to the middle octave
  always_comb begin
    case (octave)
      OCT_LOW:  hp_c = {base[CNT_W-2:0], 1'b0};
      OCT_HIGH: hp_c = {1'b0, base[CNT_W-1:1]};
      default:  hp_c = base;
    endcase
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver; note changes are applied only on half-period
// boundaries so the output never produces a runt pulse.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       buzzer,
  output logic       playing,
  output logic [3:0] cur_note
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             buzzer_q, buzzer_d;
  logic             playing_q, playing_d;
  logic [3:0]       cur_note_q, cur_note_d;

  logic [CNT_W-1:0] lut_hp_c;
  logic             lut_valid_c;
  logic             note_valid_c;
  logic             boundary_c;

  note_period_lut #(
    .CLK_FREQ (CLK_FREQ),
    .CNT_W    (CNT_W)
  ) u_lut (
    .note    (note_in),
    .octave  (octave_in),
    .hp_c    (lut_hp_c),
    .valid_c (lut_valid_c)
  );

  assign note_valid_c = enable & lut_valid_c;
  assign boundary_c   = (cnt_q == hp_q - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hp_q       <= '0;
      buzzer_q   <= 1'b0;
      playing_q  <= 1'b0;
      cur_note_q <= NOTE_REST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      buzzer_q   <= buzzer_d;
      playing_q  <= playing_d;
      cur_note_q <= cur_note_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hp_d       = hp_q;
    buzzer_d   = buzzer_q;
    playing_d  = playing_q;
    cur_note_d = cur_note_q;

    if (!enable) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      buzzer_d   = 1'b0;
      playing_d  = 1'b0;
      cur_note_d = NOTE_REST;
    end else begin
      case (state_q)
        S_IDLE: begin
          buzzer_d   = 1'b0;
          playing_d  = 1'b0;
          cur_note_d = NOTE_REST;
          if (note_valid_c) begin
            state_d    = S_PLAY;
            hp_d       = lut_hp_c;
            cnt_d      = '0;
            buzzer_d   = 1'b1;
            playing_d  = 1'b1;
            cur_note_d = note_in;
          end
        end
        S_PLAY: begin
          if (boundary_c) begin
            cnt_d = '0;
            // Inputs are only looked at here; a changed note starts on the opposite phase
            if (note_valid_c) begin
              buzzer_d   = ~buzzer_q;
              hp_d       = lut_hp_c;
              cur_note_d = note_in;
            end else begin
              state_d    = S_IDLE;
              buzzer_d   = 1'b0;
              playing_d  = 1'b0;
              cur_note_d = NOTE_REST;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign buzzer   = buzzer_q;
  assign playing  = playing_q;
  assign cur_note = cur_note_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_FREQ=1 MHz, CNT_W=12.
module tb_buzzer_tone_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       buzzer;
  logic       playing;
  logic [3:0] cur_note;

  int vectors;
  int miscompares;

  buzzer_tone_gen #(
    .CLK_FREQ (1_000_000),
    .CNT_W    (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .note_in   (note_in),
    .octave_in (octave_in),
    .buzzer    (buzzer),
    .playing   (playing),
    .cur_note  (cur_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Negedges until buzzer changes level; -1 if it never does within the budget
  task automatic wait_buzz_change(output int n);
    logic b0;
    b0 = buzzer;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (buzzer !== b0) begin
        n = i;
        return;
      end
    end
    n = -1;
  endtask

  // Negedges until playing drops; -1 on timeout
  task automatic wait_idle(output int n);
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (playing === 1'b0) begin
        n = i;
        return;
      end
    end
    n = -1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    note_in   = 4'd0;
    octave_in = 2'b01;

    wait_cycles(3);
    check("reset_buzzer", int'(buzzer), 0);
    check("reset_playing", int'(playing), 0);
    check("reset_cur_note", int'(cur_note), 0);
    reset = 1'b0;
    wait_cycles(2);
    check("idle_buzzer", int'(buzzer), 0);

    // Note 6 middle octave: hp 568
    enable  = 1'b1;
    note_in = 4'd6;
    wait_cycles(1);
    check("la_mid_latency", int'(buzzer), 1);
    check("la_mid_playing", int'(playing), 1);
    check("la_mid_cur_note", int'(cur_note), 6);
    wait_buzz_change(n);
    check("la_mid_high_len", n, 568);
    wait_buzz_change(n);
    check("la_mid_low_len", n, 568);

    // Low octave takes effect after the current half-period
    octave_in = 2'b00;
    wait_buzz_change(n);
    check("la_low_old_hp", n, 568);
    wait_buzz_change(n);
    check("la_low_hp", n, 1136);

    octave_in = 2'b10;
    wait_buzz_change(n);
    check("la_high_old_hp", n, 1136);
    wait_buzz_change(n);
    check("la_high_hp", n, 284);

    // Switch to note 1, then change to note 5 100 cycles into a half-period
    note_in   = 4'd1;
    octave_in = 2'b01;
    wait_buzz_change(n);
    check("do_old_hp", n, 284);
    wait_buzz_change(n);
    check("do_hp", n, 955);
    wait_cycles(100);
    note_in = 4'd5;
    wait_buzz_change(n);
    check("midtone_keeps_old", n + 100, 955);
    check("midtone_cur_note", int'(cur_note), 5);
    wait_buzz_change(n);
    check("so_hp", n, 637);

    // One-cycle rest glitch between boundaries is ignored
    wait_cycles(10);
    note_in = 4'd0;
    wait_cycles(1);
    note_in = 4'd5;
    wait_buzz_change(n);
    check("glitch_len", n + 11, 637);
    check("glitch_playing", int'(playing), 1);
    check("glitch_cur_note", int'(cur_note), 5);

    // Rest stops at the next boundary
    note_in = 4'd0;
    wait_idle(n);
    check("rest_len", n, 637);
    check("rest_buzzer", int'(buzzer), 0);
    check("rest_cur_note", int'(cur_note), 0);

    // End-of-song code behaves like rest
    note_in = 4'd7;
    wait_cycles(1);
    check("ti_latency", int'(buzzer), 1);
    note_in = 4'd15;
    wait_idle(n);
    check("end_len", n, 506);
    check("end_buzzer", int'(buzzer), 0);
    check("end_cur_note", int'(cur_note), 0);

    // Unused code 9 likewise
    note_in = 4'd2;
    wait_cycles(1);
    check("re_cur_note", int'(cur_note), 2);
    note_in = 4'd9;
    wait_idle(n);
    check("unused_len", n, 851);
    check("unused_buzzer", int'(buzzer), 0);

    // Enable drop mid half-period silences on the next edge
    note_in = 4'd4;
    wait_cycles(1);
    check("fa_latency", int'(buzzer), 1);
    wait_cycles(50);
    enable = 1'b0;
    wait_cycles(1);
    check("disable_buzzer", int'(buzzer), 0);
    check("disable_playing", int'(playing), 0);
    check("disable_cur_note", int'(cur_note), 0);

    // Asynchronous reset between edges, then restart on note 3
    enable  = 1'b1;
    note_in = 4'd3;
    wait_cycles(1);
    check("mi_latency", int'(buzzer), 1);
    wait_cycles(20);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_buzzer", int'(buzzer), 0);
    check("async_playing", int'(playing), 0);
    check("async_cur_note", int'(cur_note), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(1);
    check("restart_buzzer", int'(buzzer), 1);
    check("restart_cur_note", int'(cur_note), 3);
    wait_buzz_change(n);
    check("restart_hp", n, 758);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
